// File: rtl/intrapred_pkg.sv
// Shared types and helpers for the streaming intra predictor.
package intrapred_pkg;

    // Prediction mode codes; the numeric order is also the tie-break order.
    typedef enum logic [1:0] {
        MODE_V  = 2'd0,
        MODE_H  = 2'd1,
        MODE_DC = 2'd2
    } mode_t;

    // Engine FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SAD    = 3'd2,
        ST_DECIDE = 3'd3,
        ST_EMIT   = 3'd4
    } state_t;

    // SAD accumulator width: BLK*BLK terms of at most 2^PIX_W-1 each.
    function automatic int sad_width(input int pix_w, input int blk);
        return pix_w + 2 * $clog2(blk);
    endfunction

    // DC predictor used when no neighbour is available (mid-grey).
    function automatic int dc_neither(input int pix_w);
        return 1 << (pix_w - 1);
    endfunction

endpackage

// File: rtl/intrapred_dc_calc.sv
// Combinational DC predictor from the latched neighbours and their availability.
module intrapred_dc_calc
    import intrapred_pkg::*;
#(
    parameter int BLK   = 16,
    parameter int PIX_W = 8
) (
    input  logic [BLK*PIX_W-1:0] top,
    input  logic [BLK*PIX_W-1:0] left,
    input  logic                 top_avail,
    input  logic                 left_avail,
    output logic [PIX_W-1:0]     dc
);

    localparam int L     = $clog2(BLK);
    localparam int SUM_W = PIX_W + L + 1;

    logic [SUM_W-1:0] sum_top_s;
    logic [SUM_W-1:0] sum_left_s;
    logic [SUM_W-1:0] dc_wide_s;

    // Sum both neighbour edges and pick the rounded mean for the available set.
    always_comb begin
        sum_top_s  = {SUM_W{1'b0}};
        sum_left_s = {SUM_W{1'b0}};
        for (int x = 0; x < BLK; x++) begin
            sum_top_s  = sum_top_s  + SUM_W'(top[x*PIX_W +: PIX_W]);
            sum_left_s = sum_left_s + SUM_W'(left[x*PIX_W +: PIX_W]);
        end
        case ({top_avail, left_avail})
            2'b11:   dc_wide_s = (sum_top_s + sum_left_s + SUM_W'(BLK)) >> (L + 1);
            2'b10:   dc_wide_s = (sum_top_s + SUM_W'(BLK / 2)) >> L;
            2'b01:   dc_wide_s = (sum_left_s + SUM_W'(BLK / 2)) >> L;
            default: dc_wide_s = SUM_W'(dc_neither(PIX_W));
        endcase
        dc = dc_wide_s[PIX_W-1:0];
    end

endmodule

// File: rtl/intrapred_stream.sv
// Streaming V/H/DC intra predictor for one BLK x BLK block: load rows,
// accumulate three SADs, pick the cheapest eligible mode, emit residual rows.
module intrapred_stream
    import intrapred_pkg::*;
#(
    parameter int BLK            = 16,
    parameter int PIX_W          = 8,
    parameter int MB_NUMBER_BITS = 12,
    parameter int RES_W          = PIX_W + 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BLK*PIX_W-1:0]              in_row,
    input  logic [BLK*PIX_W-1:0]              in_top,
    input  logic [BLK*PIX_W-1:0]              in_left,
    input  logic                              in_top_avail,
    input  logic                              in_left_avail,
    input  logic [MB_NUMBER_BITS:0]           in_mbnumber,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BLK*RES_W-1:0]              out_row,
    output logic [1:0]                        out_mode,
    output logic [sad_width(PIX_W, BLK)-1:0]  out_sad,
    output logic [MB_NUMBER_BITS:0]           out_mbnumber,
    output logic                              out_last,
    output logic                              busy
);

    localparam int L     = $clog2(BLK);
    localparam int SAD_W = sad_width(PIX_W, BLK);
    localparam int ROW_W = BLK * PIX_W;

    state_t                  state_r;
    logic [L-1:0]            row_cnt_r;
    logic [ROW_W-1:0]        rows_r [BLK];
    logic [ROW_W-1:0]        top_r;
    logic [ROW_W-1:0]        left_r;
    logic                    top_avail_r;
    logic                    left_avail_r;
    logic [MB_NUMBER_BITS:0] mb_r;
    logic [SAD_W-1:0]        sad_v_r;
    logic [SAD_W-1:0]        sad_h_r;
    logic [SAD_W-1:0]        sad_dc_r;
    mode_t                   mode_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [BLK*RES_W-1:0]    out_row_r;
    logic [SAD_W-1:0]        out_sad_r;
    logic [MB_NUMBER_BITS:0] out_mb_r;
    logic                    out_last_r;
    logic                    busy_r;

    logic [PIX_W-1:0]        dc_s;
    logic [SAD_W-1:0]        rsum_v_s;
    logic [SAD_W-1:0]        rsum_h_s;
    logic [SAD_W-1:0]        rsum_dc_s;
    mode_t                   best_mode_s;
    logic [SAD_W-1:0]        best_sad_s;
    logic [L-1:0]            next_cnt_s;
    logic [L-1:0]            res_idx_s;
    mode_t                   res_mode_s;
    logic [BLK*RES_W-1:0]    res_row_s;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    intrapred_dc_calc #(.BLK(BLK), .PIX_W(PIX_W)) u_dc (
        .top        (top_r),
        .left       (left_r),
        .top_avail  (top_avail_r),
        .left_avail (left_avail_r),
        .dc         (dc_s)
    );

    assign next_cnt_s = row_cnt_r + L'(1);

    // Per-row absolute differences against all three predictors in parallel.
    always_comb begin
        rsum_v_s  = {SAD_W{1'b0}};
        rsum_h_s  = {SAD_W{1'b0}};
        rsum_dc_s = {SAD_W{1'b0}};
        for (int x = 0; x < BLK; x++) begin
            rsum_v_s  = rsum_v_s + SAD_W'(abs_diff(rows_r[row_cnt_r][x*PIX_W +: PIX_W],
                                                   top_r[x*PIX_W +: PIX_W]));
            rsum_h_s  = rsum_h_s + SAD_W'(abs_diff(rows_r[row_cnt_r][x*PIX_W +: PIX_W],
                                                   left_r[int'(row_cnt_r)*PIX_W +: PIX_W]));
            rsum_dc_s = rsum_dc_s + SAD_W'(abs_diff(rows_r[row_cnt_r][x*PIX_W +: PIX_W], dc_s));
        end
    end

    // Minimum-SAD choice; checking higher codes first lets lower codes win ties.
    always_comb begin
        best_mode_s = MODE_DC;
        best_sad_s  = sad_dc_r;
        if (left_avail_r && (sad_h_r <= best_sad_s)) begin
            best_mode_s = MODE_H;
            best_sad_s  = sad_h_r;
        end else begin
            best_mode_s = best_mode_s;
        end
        if (top_avail_r && (sad_v_r <= best_sad_s)) begin
            best_mode_s = MODE_V;
            best_sad_s  = sad_v_r;
        end else begin
            best_sad_s = best_sad_s;
        end
    end

    // Residual of the row about to be presented: row 0 when deciding, else the next row.
    always_comb begin
        res_row_s = {(BLK*RES_W){1'b0}};
        if (state_r == ST_DECIDE) begin
            res_idx_s  = {L{1'b0}};
            res_mode_s = best_mode_s;
        end else begin
            res_idx_s  = next_cnt_s;
            res_mode_s = mode_r;
        end
        for (int x = 0; x < BLK; x++) begin
            logic [PIX_W-1:0]        pred;
            logic signed [PIX_W:0]   diff;
            case (res_mode_s)
                MODE_V:  pred = top_r[x*PIX_W +: PIX_W];
                MODE_H:  pred = left_r[int'(res_idx_s)*PIX_W +: PIX_W];
                default: pred = dc_s;
            endcase
            diff = signed'({1'b0, rows_r[res_idx_s][x*PIX_W +: PIX_W]}) - signed'({1'b0, pred});
            res_row_s[x*RES_W +: RES_W] = RES_W'(diff);
        end
    end

    // Engine FSM: row capture, SAD accumulation, mode decision and residual emission.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            row_cnt_r    <= {L{1'b0}};
            for (int i = 0; i < BLK; i++) rows_r[i] <= {ROW_W{1'b0}};
            top_r        <= {ROW_W{1'b0}};
            left_r       <= {ROW_W{1'b0}};
            top_avail_r  <= 1'b0;
            left_avail_r <= 1'b0;
            mb_r         <= {(MB_NUMBER_BITS+1){1'b0}};
            sad_v_r      <= {SAD_W{1'b0}};
            sad_h_r      <= {SAD_W{1'b0}};
            sad_dc_r     <= {SAD_W{1'b0}};
            mode_r       <= MODE_V;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_row_r    <= {(BLK*RES_W){1'b0}};
            out_sad_r    <= {SAD_W{1'b0}};
            out_mb_r     <= {(MB_NUMBER_BITS+1){1'b0}};
            out_last_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        rows_r[0]    <= in_row;
                        top_r        <= in_top;
                        left_r       <= in_left;
                        top_avail_r  <= in_top_avail;
                        left_avail_r <= in_left_avail;
                        mb_r         <= in_mbnumber;
                        sad_v_r      <= {SAD_W{1'b0}};
                        sad_h_r      <= {SAD_W{1'b0}};
                        sad_dc_r     <= {SAD_W{1'b0}};
                        row_cnt_r    <= L'(1);
                        busy_r       <= 1'b1;
                        state_r      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        rows_r[row_cnt_r] <= in_row;
                        if (row_cnt_r == L'(BLK - 1)) begin
                            row_cnt_r  <= {L{1'b0}};
                            in_ready_r <= 1'b0;
                            state_r    <= ST_SAD;
                        end else begin
                            row_cnt_r <= next_cnt_s;
                        end
                    end
                end
                ST_SAD: begin
                    sad_v_r  <= sad_v_r + rsum_v_s;
                    sad_h_r  <= sad_h_r + rsum_h_s;
                    sad_dc_r <= sad_dc_r + rsum_dc_s;
                    if (row_cnt_r == L'(BLK - 1)) begin
                        row_cnt_r <= {L{1'b0}};
                        state_r   <= ST_DECIDE;
                    end else begin
                        row_cnt_r <= next_cnt_s;
                    end
                end
                ST_DECIDE: begin
                    mode_r      <= best_mode_s;
                    out_sad_r   <= best_sad_s;
                    out_mb_r    <= mb_r;
                    out_row_r   <= res_row_s;
                    out_last_r  <= 1'b0;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (row_cnt_r == L'(BLK - 1)) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            row_cnt_r   <= {L{1'b0}};
                            busy_r      <= 1'b0;
                            in_ready_r  <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else begin
                            row_cnt_r  <= next_cnt_s;
                            out_row_r  <= res_row_s;
                            out_last_r <= (next_cnt_s == L'(BLK - 1));
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_row      = out_row_r;
    assign out_mode     = mode_r;
    assign out_sad      = out_sad_r;
    assign out_mbnumber = out_mb_r;
    assign out_last     = out_last_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_intrapred_stream.sv
// Directed bench: BLK=4 mode/latency vectors, BLK=8 backpressure, BLK=16 mid-block reset.
module tb_intrapred_stream;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // BLK=4 instance
    logic        in_valid4, in_ready4, ta4, la4, out_valid4, out_ready4, out_last4, busy4;
    logic [31:0] in_row4, in_top4, in_left4;
    logic [12:0] mb4, out_mb4;
    logic [35:0] out_row4;
    logic [1:0]  out_mode4;
    logic [11:0] out_sad4;

    // BLK=8 instance
    logic        in_valid8, in_ready8, ta8, la8, out_valid8, out_ready8, out_last8, busy8;
    logic [63:0] in_row8, in_top8, in_left8;
    logic [12:0] mb8, out_mb8;
    logic [71:0] out_row8;
    logic [1:0]  out_mode8;
    logic [13:0] out_sad8;

    // BLK=16 instance
    logic         in_valid16, in_ready16, ta16, la16, out_valid16, out_ready16, out_last16, busy16;
    logic [127:0] in_row16, in_top16, in_left16;
    logic [12:0]  mb16, out_mb16;
    logic [143:0] out_row16;
    logic [1:0]   out_mode16;
    logic [15:0]  out_sad16;

    intrapred_stream #(.BLK(4)) u4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_row(in_row4), .in_top(in_top4), .in_left(in_left4),
        .in_top_avail(ta4), .in_left_avail(la4), .in_mbnumber(mb4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_row(out_row4),
        .out_mode(out_mode4), .out_sad(out_sad4), .out_mbnumber(out_mb4),
        .out_last(out_last4), .busy(busy4));

    intrapred_stream #(.BLK(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_row(in_row8), .in_top(in_top8), .in_left(in_left8),
        .in_top_avail(ta8), .in_left_avail(la8), .in_mbnumber(mb8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_row(out_row8),
        .out_mode(out_mode8), .out_sad(out_sad8), .out_mbnumber(out_mb8),
        .out_last(out_last8), .busy(busy8));

    intrapred_stream #(.BLK(16)) u16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_row(in_row16), .in_top(in_top16), .in_left(in_left16),
        .in_top_avail(ta16), .in_left_avail(la16), .in_mbnumber(mb16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_row(out_row16),
        .out_mode(out_mode16), .out_sad(out_sad16), .out_mbnumber(out_mb16),
        .out_last(out_last16), .busy(busy16));

    // Single comparison point: counts every vector and reports mismatches.
    task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One BLK=4 block with uniform pixels/neighbours; checks latency, rows and flags.
    task automatic run4(input string name, input logic [7:0] pix, input logic [7:0] top,
                        input logic [7:0] left, input logic ta, input logic la,
                        input logic [12:0] mb, input logic [1:0] emode,
                        input logic [11:0] esad, input logic [8:0] eres, input bit chk_lat);
        int k;
        logic [35:0] erow;
        for (int x = 0; x < 4; x++) erow[x*9 +: 9] = eres;
        out_ready4 = 1'b1;
        @(negedge clk);
        check_val({name, "_in_ready"}, in_ready4, 1'b1);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                in_row4[x*8 +: 8]  = pix;
                in_top4[x*8 +: 8]  = (y == 0) ? top : 8'hEE;
                in_left4[x*8 +: 8] = (y == 0) ? left : 8'hEE;
            end
            ta4 = (y == 0) ? ta : ~ta;
            la4 = (y == 0) ? la : ~la;
            mb4 = (y == 0) ? mb : 13'h1FFF;
            in_valid4 = 1'b1;
            @(negedge clk);
        end
        in_valid4 = 1'b0;
        k = 4;
        while (!out_valid4 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (chk_lat) check_val({name, "_latency"}, k, 9);
        if (!out_valid4) begin
            check_val({name, "_timeout"}, out_valid4, 1'b1);
        end else begin
            check_val({name, "_mode"}, out_mode4, emode);
            check_val({name, "_sad"}, out_sad4, esad);
            check_val({name, "_mb"}, out_mb4, mb);
            for (int r = 0; r < 4; r++) begin
                check_val($sformatf("%s_valid%0d", name, r), out_valid4, 1'b1);
                check_val($sformatf("%s_row%0d", name, r), out_row4, erow);
                check_val($sformatf("%s_last%0d", name, r), out_last4, (r == 3));
                @(negedge clk);
            end
            check_val({name, "_valid_end"}, out_valid4, 1'b0);
            check_val({name, "_busy_end"}, busy4, 1'b0);
            check_val({name, "_ready_end"}, in_ready4, 1'b1);
        end
    endtask

    initial begin
        int idx;
        int stall;
        int guard;
        logic [71:0]  erow8;
        logic [143:0] erow16;

        reset = 1'b1;
        {in_valid4, in_valid8, in_valid16} = 3'b000;
        {out_ready4, out_ready8, out_ready16} = 3'b111;
        in_row4 = '0; in_top4 = '0; in_left4 = '0; ta4 = 1'b0; la4 = 1'b0; mb4 = '0;
        in_row8 = '0; in_top8 = '0; in_left8 = '0; ta8 = 1'b0; la8 = 1'b0; mb8 = '0;
        in_row16 = '0; in_top16 = '0; in_left16 = '0; ta16 = 1'b0; la16 = 1'b0; mb16 = '0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", in_ready4, 1'b1);
        check_val("rst_out_valid", out_valid4, 1'b0);
        check_val("rst_busy", busy4, 1'b0);
        check_val("rst_mode_sad", {out_mode4, out_sad4, out_last4}, 15'd0);
        reset = 1'b0;

        // V wins on flat block; DC (75) and H (50) worse.
        run4("v_flat", 8'd100, 8'd100, 8'd50, 1'b1, 1'b1, 13'd5, 2'd0, 12'd0, 9'h000, 1'b1);
        // All three SAD 0: lowest code wins.
        run4("tie_all", 8'd100, 8'd100, 8'd100, 1'b1, 1'b1, 13'd6, 2'd0, 12'd0, 9'h000, 1'b0);
        // No neighbours: DC=128 forced, residual -128.
        run4("dc_none", 8'd0, 8'd100, 8'd50, 1'b0, 1'b0, 13'd7, 2'd2, 12'd2048, 9'h180, 1'b0);
        // H and DC both SAD 0: H wins the tie.
        run4("h_tie", 8'd2, 8'd1, 8'd2, 1'b1, 1'b1, 13'd8, 2'd1, 12'd0, 9'h000, 1'b0);

        // BLK=8: row y = 20+10y, top 20, left 200 -> V, SAD 2240, residual 10y; stall on row 3.
        @(negedge clk);
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                in_row8[x*8 +: 8]  = 8'(20 + 10 * y);
                in_top8[x*8 +: 8]  = 8'd20;
                in_left8[x*8 +: 8] = 8'd200;
            end
            ta8 = 1'b1; la8 = 1'b1; mb8 = 13'd300;
            in_valid8 = 1'b1;
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        guard = 0;
        while (!out_valid8 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check_val("b8_valid", out_valid8, 1'b1);
        check_val("b8_mode", out_mode8, 2'd0);
        check_val("b8_sad", out_sad8, 14'd2240);
        check_val("b8_mb", out_mb8, 13'd300);
        idx = 0; stall = 0; guard = 0;
        while (idx < 8 && guard < 40 && out_valid8) begin
            for (int x = 0; x < 8; x++) erow8[x*9 +: 9] = 9'(10 * idx);
            check_val($sformatf("b8_row%0d", idx), out_row8, erow8);
            check_val($sformatf("b8_last%0d", idx), out_last8, (idx == 7));
            if (idx == 3 && stall < 5) begin
                out_ready8 = 1'b0;
                check_val($sformatf("b8_in_ready_stall%0d", stall), in_ready8, 1'b0);
                stall++;
            end else begin
                out_ready8 = 1'b1;
                idx++;
            end
            guard++;
            @(negedge clk);
        end
        check_val("b8_rows_done", idx, 8);
        check_val("b8_valid_end", out_valid8, 1'b0);

        // BLK=16: flat V block, reset while row 5 is presented.
        @(negedge clk);
        for (int y = 0; y < 16; y++) begin
            in_row16 = {16{8'd50}}; in_top16 = {16{8'd50}}; in_left16 = '0;
            ta16 = 1'b1; la16 = 1'b0; mb16 = 13'd11;
            in_valid16 = 1'b1;
            @(negedge clk);
        end
        in_valid16 = 1'b0;
        guard = 0;
        while (!out_valid16 && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        check_val("b16a_valid", out_valid16, 1'b1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("b16_rst_valid", out_valid16, 1'b0);
        check_val("b16_rst_busy", busy16, 1'b0);
        check_val("b16_rst_in_ready", in_ready16, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        // Fresh block: row y = y+3, left[y] = y, left only -> H, residual 3, SAD 768.
        @(negedge clk);
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                in_row16[x*8 +: 8]  = 8'(y + 3);
                in_left16[x*8 +: 8] = 8'(x);
                in_top16[x*8 +: 8]  = 8'd250;
            end
            ta16 = 1'b0; la16 = 1'b1; mb16 = 13'd77;
            in_valid16 = 1'b1;
            @(negedge clk);
        end
        in_valid16 = 1'b0;
        guard = 0;
        while (!out_valid16 && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        check_val("b16_valid", out_valid16, 1'b1);
        check_val("b16_mode", out_mode16, 2'd1);
        check_val("b16_sad", out_sad16, 16'd768);
        check_val("b16_mb", out_mb16, 13'd77);
        erow16 = {16{9'd3}};
        idx = 0;
        while (idx < 16 && out_valid16) begin
            check_val($sformatf("b16_row%0d", idx), out_row16, erow16);
            check_val($sformatf("b16_last%0d", idx), out_last16, (idx == 15));
            idx++;
            @(negedge clk);
        end
        check_val("b16_rows_done", idx, 16);
        check_val("b16_valid_end", out_valid16, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/intrapred_stream.md
Name: intrapred_stream

Overview:
- Parametrised, handshaked single-component intra predictor: replaces the fixed all-at-once, enable-chained flow with a streaming engine for one BLK x BLK block.
- Accepts block rows plus neighbour pixels over valid/ready, evaluates V/H/DC prediction with availability masking, and picks the minimum-SAD mode.
- Streams signed residual rows of the winning mode out with backpressure.
- One instance per component (luma16x16, chroma8x8, luma4x4 DC-class), feeding the transform stage.

Parameters:
- BLK, 16: block edge in pixels; legal values 4, 8, 16.
- PIX_W, 8: pixel width in bits.
- MB_NUMBER_BITS, 12: macroblock number port is MB_NUMBER_BITS+1 bits wide.
- RES_W, PIX_W+1: signed residual width; must be >= PIX_W+1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input row valid.
- in_ready  out  1  engine can accept a row.
- in_row  in  BLK*PIX_W  original pixels of one row; pixel x at bits [x*PIX_W +: PIX_W].
- in_top  in  BLK*PIX_W  top neighbours; sampled with row 0 only.
- in_left  in  BLK*PIX_W  left neighbours; sampled with row 0 only.
- in_top_avail  in  1  top neighbours valid; sampled with row 0.
- in_left_avail  in  1  left neighbours valid; sampled with row 0.
- in_mbnumber  in  MB_NUMBER_BITS+1  block tag; sampled with row 0.
- out_valid  out  1  residual row valid.
- out_ready  in  1  downstream accepts.
- out_row  out  BLK*RES_W  signed residuals of one row.
- out_mode  out  2  chosen mode: 0=V, 1=H, 2=DC.
- out_sad  out  PIX_W+2*log2(BLK)  SAD of the chosen mode.
- out_mbnumber  out  MB_NUMBER_BITS+1  tag of the block being emitted.
- out_last  out  1  high on the final row of the block.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, reset=1): FSM=IDLE, row counter=0; all outputs 0 except in_ready=1.
- States: IDLE, LOAD, SAD, DECIDE, EMIT.
- IDLE: in_ready=1. On in_valid&in_ready:
  - store row 0;
  - latch top, left, both avail flags and mbnumber;
  - go to LOAD (or to SAD if BLK... never; BLK>=4).
- LOAD: in_ready=1. Store rows 1..BLK-1 in order; after row BLK-1 go to SAD. in_valid low simply stalls; no timeout.
- SAD: in_ready=0. One stored row per cycle; three accumulators add |row-pred| per pixel in parallel. BLK cycles, then go to DECIDE.
- Predictors:
  - V[x][y] = top[x]; H[x][y] = left[y].
  - DC, with L = log2(BLK):
    - both available: (sum top + sum left + BLK) >> (L+1);
    - top only: (sum top + BLK/2) >> L;
    - left only: (sum left + BLK/2) >> L;
    - neither: 1 << (PIX_W-1).
  - DC is computed from latched neighbours, stable before SAD starts.
- Unavailable modes: V is excluded when !top_avail; H is excluded when !left_avail. DC is always eligible.
- DECIDE (1 cycle): choose the minimum SAD among eligible modes; ties go to the lowest mode code. Latch out_mode and out_sad, then go to EMIT.
- EMIT:
  - out_valid=1; out_row = stored row - pred, sign-extended to RES_W; out_last = (row==BLK-1).
  - Row advances only on out_valid&out_ready. While out_ready=0, out_row/out_mode/out_sad/out_mbnumber/out_last stay stable.
  - After the last handshake, go to IDLE with out_valid=0 the next cycle.
- Latency: with no stalls, row 0 accepted at cycle 0 gives first out_valid at cycle 2*BLK+1. Minimum block period is 3*BLK+1 cycles.
- Simultaneity: in_ready=0 throughout SAD/DECIDE/EMIT, so no overlap of blocks; the next row 0 is accepted in IDLE only.
- Widths: SAD accumulators are PIX_W+2L bits and cannot overflow; residuals lie in [-(2^PIX_W-1), 2^PIX_W-1].
- Reset mid-operation: immediate return to the reset state. The partial block is discarded; no out_valid is emitted for it.

Decomposition:
- Package intrapred_pkg holds:
  - mode enum (MODE_V=0, MODE_H=1, MODE_DC=2);
  - FSM state typedef;
  - function clog2-based SAD width;
  - DC-for-neither constant.
- One sub-module, intrapred_dc_calc: combinational DC value from latched neighbours and avail flags, parametrised by BLK and PIX_W.

Test Plan:
- BLK=4: all pixels 100, top=100, left=50, both avail -> mode 0, sad 0, four rows of residual 0; out_last on row 3 only; first out_valid at cycle 9.
- BLK=4: pixels 100, top=left=100 -> V/H/DC all SAD 0 -> tie-break gives mode 0.
- BLK=4: neither avail, pixels 0 -> DC=128, mode 2, sad 2048, every residual -128 (RES_W=9 = 0x180).
- BLK=4: top all 1, left all 2, both avail, pixels 2 -> DC=(4+8+4)>>3=2; H SAD 0 wins (mode 1 beats DC 2 on tie).
- BLK=8: hold out_ready=0 for 5 cycles on row 3 -> out_row/out_last stable; in_ready stays 0; resuming yields rows 3..7 in order.
- BLK=16: assert reset during EMIT row 5 -> out_valid=0 and busy=0 immediately; in_ready=1. A fresh block then completes normally with the new mbnumber.
